div_seq: RTL
============

# div_seq

Multi-cycle restoring divider for the exper_03 datapath. Arithmetic runs the reverse way from the adder/subtractor: instead of building a result by addition, it decomposes a dividend by repeated trial subtraction. One n-bit quotient/remainder pair is produced per transaction, over valid/ready handshakes on both sides. It sits beside the add/sub unit as the divide path of the small ALU.

## Interface
- n, default 8: operand, quotient and remainder width (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept; high only in IDLE.
- a  input  n  dividend.
- b  input  n  divisor.
- is_signed  input  1  two's-complement mode. Present only with DIV_SIGNED_EN.
- out_valid  output  1  result held.
- out_ready  input  1  consumer takes result.
- quotient  output  n  quotient.
- remainder  output  n  remainder.
- div_zero  output  1  divisor was zero.
- overflow  output  1  signed overflow (most-negative / −1); constant 0 without DIV_SIGNED_EN.

## Operation
- States: IDLE, CALC, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch a and b, clear the partial remainder, step counter=0.
  - If b==0, go to DONE with: quotient all ones, remainder=a, div_zero=1.
  - Otherwise go to CALC.
- CALC, one restoring step per cycle:
  - Shift the {partial remainder, dividend} pair left by 1.
  - Trial-subtract the divisor from the upper n+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After step n−1, go to DONE.
- DONE
  - out_valid=1; quotient, remainder and flags held stable.
  - On out_valid&&out_ready, go to IDLE.
  - in_ready stays 0 during the handoff cycle, so there is no same-cycle re-accept.
- Inputs a, b and is_signed are ignored outside the accept cycle.
- Partial-remainder datapath is n+1 bits wide. The subtract borrow decides each quotient bit.
- Reset (asynchronous, any state, including mid-CALC):
  - state=IDLE.
  - out_valid=0, quotient=0, remainder=0, div_zero=0, overflow=0.
  - The in-flight operation is discarded.
  - in_ready=1 once rst_n deasserts.

## Timing
- Accept at clock edge T0:
  - b≠0: out_valid rises after edge Tn, i.e. n cycles of CALC.
  - b==0: out_valid rises after edge T1.
- Throughput, no backpressure: n+2 cycles per operation (accept, n steps, handoff).
- out_ready held low: DONE persists indefinitely with outputs frozen.
- in_ready and out_valid are never high together.

## Configuration
- DIV_SIGNED_EN defined:
  - Port is_signed exists.
  - With is_signed=1, operand magnitudes are divided unsigned.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend (truncating division).
  - Most-negative / −1 gives quotient=most-negative, remainder=0, overflow=1.
  - Divide-by-zero gives quotient all ones (−1), remainder=a, div_zero=1.
  - Sign fix-up happens on the CALC→DONE transition; latency is unchanged.
- DIV_SIGNED_EN undefined: unsigned only, is_signed port absent, overflow tied 0.

## Structure
- Shared package div_pkg:
  - State encoding (IDLE/CALC/DONE).
  - Counter width $clog2(n).
  - Divide-by-zero quotient constant (all ones).
- One sub-module, div_sub_step: combinational n+1-bit trial subtract. Returns the next partial remainder and the quotient bit; one instance per core.

## Test plan
- a=200, b=7, unsigned, out_ready=1 → quotient=28, remainder=4, div_zero=0; out_valid exactly 8 cycles after the accept edge.
- a=5, b=0 → quotient=0xFF, remainder=5, div_zero=1; out_valid 1 cycle after accept.
- a=3, b=10, then a=255, b=1 back-to-back → (0, 3) then (255, 0); in_ready low during the handoff cycle.
- a=100, b=9 with out_ready held low for 5 cycles after out_valid → outputs stay quotient=11, remainder=1 throughout; transfer occurs on the first out_ready=1 edge.
- Accept a=200, b=7, then pull rst_n low at CALC step 3 → all outputs 0 immediately, state IDLE. A following a=50, b=5 yields (10, 0).
- DIV_SIGNED_EN, is_signed=1:
  - a=0xF9 (−7), b=2 → quotient=0xFD (−3), remainder=0xFF (−1).
  - a=0x80, b=0xFF → quotient=0x80, remainder=0, overflow=1.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// States, counter sizing and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF = 8;
    localparam int N_MAX = 64;

    // Divide-by-zero quotient: all ones, sliced to the operand width.
    localparam logic [N_MAX-1:0] DZ_QUOT = '1;

    // Step counter width for an n-bit divide.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/div_sub_step.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted n+1-bit partial remainder; the borrow decides the quotient bit.
module div_sub_step
    import div_pkg::*;
#(
    parameter int n = N_DEF
)
(
    input  logic [n:0]   pr,
    input  logic [n-1:0] d,
    output logic [n:0]   next,
    output logic         qbit
);

    logic [n+1:0] diff;

    // Subtract with one extra bit so the top bit is the borrow.
    always_comb begin
        diff = {1'b0, pr} - {2'b00, d};
        qbit = ~diff[n+1];
        next = qbit ? diff[n:0] : pr;
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider with valid/ready handshakes on both sides.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN.
module div_seq
    import div_pkg::*;
#(
    parameter int n = N_DEF
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
`ifdef DIV_SIGNED_EN
    input  logic         is_signed,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         div_zero,
    output logic         overflow
);

    localparam int CW = cnt_width(n);

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  cnt;
    logic [n:0]     pr;
    logic [n-1:0]   dvd;
    logic [n-1:0]   dvs;
    logic           dz_p;
    logic           neg_q;
    logic           neg_r;

    logic           accept;
    logic           last;
    logic           sgn;
    logic           a_neg;
    logic           b_neg;
    logic [n-1:0]   a_mag;
    logic [n-1:0]   b_mag;
    logic [n:0]     pr_sh;
    logic [n:0]     pr_nx;
    logic           qbit;
    logic [n-1:0]   q_raw;
    logic [n-1:0]   q_fin;
    logic [n-1:0]   r_fin;

`ifdef DIV_SIGNED_EN
    assign sgn = is_signed;
`else
    assign sgn = 1'b0;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (state == CALC) && (cnt == CW'(n - 1));
    assign pr_sh  = {pr[n-1:0], dvd[n-1]};
    assign a_neg  = sgn & a[n-1];
    assign b_neg  = sgn & b[n-1];
    assign a_mag  = a_neg ? -a : a;
    assign b_mag  = b_neg ? -b : b;
    assign q_raw  = {dvd[n-2:0], qbit};

    div_sub_step #(.n(n)) u_step (
        .pr   (pr_sh),
        .d    (dvs),
        .next (pr_nx),
        .qbit (qbit)
    );

    // Final result with sign fix-up; divide-by-zero returns the raw dividend.
    always_comb begin
        q_fin = neg_q ? -q_raw : q_raw;
        r_fin = neg_r ? -pr_nx[n-1:0] : pr_nx[n-1:0];
        if (dz_p) begin
            q_fin = DZ_QUOT[n-1:0];
            r_fin = dvd;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = CALC;
            end
            CALC: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, one shift/subtract step per cycle, result load.
    // A zero divisor runs a single dummy step so its result lands one edge
    // after the accept, keeping the result register path shared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            pr        <= '0;
            dvd       <= '0;
            dvs       <= '0;
            dz_p      <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else if (accept) begin
            cnt   <= (b == '0) ? CW'(n - 1) : '0;
            pr    <= '0;
            dvd   <= (b == '0) ? a : a_mag;
            dvs   <= b_mag;
            dz_p  <= (b == '0);
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            pr  <= pr_nx;
            dvd <= q_raw;
            if (last) begin
                quotient  <= q_fin;
                remainder <= r_fin;
                div_zero  <= dz_p;
            end
        end
    end

`ifdef DIV_SIGNED_EN
    logic ov_p;

    // Most-negative / -1 is flagged; the magnitude path already yields MIN, 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_p     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            ov_p <= sgn && (a == {1'b1, {(n-1){1'b0}}}) && (b == '1);
        end else if (last) begin
            overflow <= ov_p && !dz_p;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
